// File: rtl/tlc_pkg.sv
// Shared lamp encodings, monitor modes and fault cause codes for the signal conflict monitor.
// Also holds the small code-classification helpers used by the checker.
// No logic of its own; imported by every monitor file.
package tlc_pkg;

  localparam logic [2:0] LAMP_GREEN  = 3'b001;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_OFF    = 3'b000;

  typedef enum logic [1:0] {
    STARTUP = 2'd0,
    NORMAL  = 2'd1,
    FLASH   = 2'd2
  } mode_t;

  localparam logic [1:0] FC_NONE     = 2'd0;
  localparam logic [1:0] FC_INVALID  = 2'd1;
  localparam logic [1:0] FC_CONFLICT = 2'd2;
  localparam logic [1:0] FC_STUCK    = 2'd3;

  // A code is legal only if it is exactly one of green, yellow or red.
  function automatic logic code_ok(input logic [2:0] code);
    return (code == LAMP_GREEN) || (code == LAMP_YELLOW) || (code == LAMP_RED);
  endfunction

  // Anything other than solid red grants (or may grant) right-of-way.
  function automatic logic is_active(input logic [2:0] code);
    return code != LAMP_RED;
  endfunction

endpackage

// File: rtl/signal_conflict_check.sv
// Combinational classifier of one light-code sample: invalid encoding and conflicting right-of-way.
// Zero latency, no state.
// No flow control; outputs follow inputs.
module signal_conflict_check
  import tlc_pkg::*;
(
  input  logic [2:0] light_M1,
  input  logic [2:0] light_M2,
  input  logic [2:0] light_MT,
  input  logic [2:0] light_S,
  output logic       invalid,
  output logic       conflict
);

  logic act_m1, act_m2, act_mt, act_s;

  assign act_m1 = is_active(light_M1);
  assign act_m2 = is_active(light_M2);
  assign act_mt = is_active(light_MT);
  assign act_s  = is_active(light_S);

  assign invalid = !code_ok(light_M1) || !code_ok(light_M2) ||
                   !code_ok(light_MT) || !code_ok(light_S);

  // Side road excludes every main movement; the turn excludes opposing main road 2.
  // M1 may run with M2 or with the turn.
  assign conflict = (act_s && (act_m1 || act_m2 || act_mt)) || (act_mt && act_m2);

endmodule

// File: rtl/signal_conflict_monitor.sv
// Registers controller light codes to the lamps and trips a latched flashing-red mode on bad samples.
// Latency 1 cycle input-to-lamp in NORMAL; violating samples are replaced by all-red.
// No backpressure; a fault holds FLASH until a clear on a clean sample or reset.
module signal_conflict_monitor
  import tlc_pkg::*;
#(
  parameter int FILTER_CYCLES  = 2,
  parameter int STUCK_CYCLES   = 16,
  parameter int STARTUP_CYCLES = 3,
  parameter int FLASH_HALF     = 1
)(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] light_M1,
  input  logic [2:0] light_M2,
  input  logic [2:0] light_MT,
  input  logic [2:0] light_S,
  input  logic       clear_fault,
  output logic [2:0] lamp_M1,
  output logic [2:0] lamp_M2,
  output logic [2:0] lamp_MT,
  output logic [2:0] lamp_S,
  output logic       fault,
  output logic [1:0] fault_code,
  output logic [1:0] mode
);

  localparam logic [3:0]  FILT_LIM    = 4'(FILTER_CYCLES);
  localparam logic [7:0]  STUCK_LIM   = 8'(STUCK_CYCLES);
  localparam logic [7:0]  STARTUP_LIM = 8'(STARTUP_CYCLES);
  localparam logic [7:0]  FLASH_LIM   = 8'(FLASH_HALF);
  localparam logic [11:0] ALL_RED     = {4{LAMP_RED}};
  localparam logic [11:0] ALL_OFF     = {4{LAMP_OFF}};

  mode_t       state;
  logic [11:0] lamp_q;
  logic [11:0] prev_sample;
  logic [3:0]  filt_cnt;
  logic [7:0]  stuck_cnt;
  logic [7:0]  startup_cnt;
  logic [7:0]  flash_cnt;
  logic        flash_on;

  logic        invalid, conflict, violation;
  logic [11:0] sample;
  logic        same;
  logic        filt_trip, stuck_trip;

  signal_conflict_check u_check (
    .light_M1 (light_M1),
    .light_M2 (light_M2),
    .light_MT (light_MT),
    .light_S  (light_S),
    .invalid  (invalid),
    .conflict (conflict)
  );

  assign violation  = invalid | conflict;
  assign sample     = {light_M1, light_M2, light_MT, light_S};
  assign same       = (sample == prev_sample);
  // Trip on the violating sample that would bring the filter count to its limit.
  assign filt_trip  = violation && (filt_cnt >= FILT_LIM - 4'd1);
  // Trip on the repeat that would bring the stuck count to its limit.
  assign stuck_trip = same && (stuck_cnt >= STUCK_LIM - 8'd1);

  assign {lamp_M1, lamp_M2, lamp_MT, lamp_S} = lamp_q;
  assign mode = state;

  // Mode sequencing, fault latching, all counters and the lamp register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= STARTUP;
      lamp_q      <= ALL_RED;
      fault       <= 1'b0;
      fault_code  <= FC_NONE;
      filt_cnt    <= '0;
      stuck_cnt   <= '0;
      startup_cnt <= '0;
      flash_cnt   <= '0;
      flash_on    <= 1'b1;
      prev_sample <= '0;
    end else begin
      prev_sample <= sample;
      case (state)
        STARTUP: begin
          lamp_q    <= ALL_RED;
          filt_cnt  <= '0;
          stuck_cnt <= '0;
          if (startup_cnt >= STARTUP_LIM - 8'd1) begin
            state       <= NORMAL;
            startup_cnt <= '0;
          end else begin
            startup_cnt <= startup_cnt + 8'd1;
          end
        end

        NORMAL: begin
          if (!violation)              filt_cnt <= '0;
          else if (filt_cnt < FILT_LIM) filt_cnt <= filt_cnt + 4'd1;

          if (!same)                      stuck_cnt <= '0;
          else if (stuck_cnt < STUCK_LIM) stuck_cnt <= stuck_cnt + 8'd1;

          if (filt_trip || stuck_trip) begin
            state      <= FLASH;
            fault      <= 1'b1;
            fault_code <= filt_trip ? (invalid ? FC_INVALID : FC_CONFLICT) : FC_STUCK;
            lamp_q     <= ALL_RED;
            filt_cnt   <= '0;
            stuck_cnt  <= '0;
            flash_cnt  <= '0;
            flash_on   <= 1'b1;
          end else if (violation) begin
            lamp_q <= ALL_RED;
          end else begin
            lamp_q <= sample;
          end
        end

        FLASH: begin
          // A clear is honoured only when the controller is presenting a legal, safe sample.
          if (clear_fault && !violation) begin
            state       <= STARTUP;
            fault       <= 1'b0;
            fault_code  <= FC_NONE;
            stuck_cnt   <= '0;
            startup_cnt <= '0;
            lamp_q      <= ALL_RED;
          end else if (flash_cnt >= FLASH_LIM - 8'd1) begin
            flash_cnt <= '0;
            flash_on  <= ~flash_on;
            lamp_q    <= flash_on ? ALL_OFF : ALL_RED;
          end else begin
            flash_cnt <= flash_cnt + 8'd1;
            lamp_q    <= flash_on ? ALL_RED : ALL_OFF;
          end
        end

        default: begin
          state  <= STARTUP;
          lamp_q <= ALL_RED;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_signal_conflict_monitor.sv
// Directed-vector bench for signal_conflict_monitor with a queue-based scoreboard.
// Driver pushes the hand-computed post-edge expectation for each vector it applies.
// Monitor pops one entry after every clock edge that has one pending and compares it.
module tb_signal_conflict_monitor;

  localparam logic [2:0]  G  = 3'b001;
  localparam logic [2:0]  Y  = 3'b010;
  localparam logic [2:0]  R  = 3'b100;
  localparam logic [11:0] N  = {G, G, R, R};           // main roads green
  localparam logic [11:0] N2 = {Y, Y, R, R};           // main roads yellow
  localparam logic [11:0] C  = {G, R, R, G};           // side green against M1 green
  localparam logic [11:0] GL = {G, 3'b011, R, R};      // multi-hot M2
  localparam logic [11:0] IC = {G, R, R, 3'b110};      // invalid side code, also active
  localparam logic [11:0] AR = {R, R, R, R};
  localparam logic [11:0] AO = 12'h000;

  typedef struct {
    logic [11:0] lamps;
    logic        f;
    logic [1:0]  c;
    logic [1:0]  m;
    int          id;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] light_M1 = R, light_M2 = R, light_MT = R, light_S = R;
  logic       clear_fault = 1'b0;
  logic [2:0] lamp_M1, lamp_M2, lamp_MT, lamp_S;
  logic       fault;
  logic [1:0] fault_code;
  logic [1:0] mode;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   step_no = 0;

  always #5 clk = ~clk;

  signal_conflict_monitor dut (
    .clk         (clk),
    .rst         (rst),
    .light_M1    (light_M1),
    .light_M2    (light_M2),
    .light_MT    (light_MT),
    .light_S     (light_S),
    .clear_fault (clear_fault),
    .lamp_M1     (lamp_M1),
    .lamp_M2     (lamp_M2),
    .lamp_MT     (lamp_MT),
    .lamp_S      (lamp_S),
    .fault       (fault),
    .fault_code  (fault_code),
    .mode        (mode)
  );

  // Apply one vector before the next edge and record what the outputs must be after that edge.
  task automatic step(input logic r, input logic clr, input logic [11:0] vec,
                      input logic [11:0] el, input logic ef, input logic [1:0] ec,
                      input logic [1:0] em);
    exp_t e;
    @(negedge clk);
    rst         = r;
    clear_fault = clr;
    {light_M1, light_M2, light_MT, light_S} = vec;
    e.lamps = el;
    e.f     = ef;
    e.c     = ec;
    e.m     = em;
    e.id    = step_no;
    exp_q.push_back(e);
    step_no++;
  endtask

  // Monitor: outputs are presented every cycle; compare whenever an expectation is pending.
  initial begin
    exp_t e;
    logic [11:0] got;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
        e   = exp_q.pop_front();
        got = {lamp_M1, lamp_M2, lamp_MT, lamp_S};
        total++;
        if (got !== e.lamps) begin
          bad++;
          $display("FAIL lamps step=%0d got=%h want=%h", e.id, got, e.lamps);
        end
        total++;
        if (fault !== e.f) begin
          bad++;
          $display("FAIL fault step=%0d got=%b want=%b", e.id, fault, e.f);
        end
        total++;
        if (fault_code !== e.c) begin
          bad++;
          $display("FAIL fault_code step=%0d got=%0d want=%0d", e.id, fault_code, e.c);
        end
        total++;
        if (mode !== e.m) begin
          bad++;
          $display("FAIL mode step=%0d got=%0d want=%0d", e.id, mode, e.m);
        end
      end
    end
  end

  initial begin
    // Reset state.
    step(1, 0, N, AR, 0, 0, 0);
    step(1, 0, N, AR, 0, 0, 0);

    // Startup hold: three cycles in STARTUP, all red also on the entry into NORMAL.
    step(0, 0, N,  AR, 0, 0, 0);
    step(0, 0, N,  AR, 0, 0, 0);
    step(0, 0, N,  AR, 0, 0, 1);
    // Normal forwarding, one cycle latency.
    step(0, 0, N,  N,  0, 0, 1);
    step(0, 0, N2, N2, 0, 0, 1);
    step(0, 0, N,  N,  0, 0, 1);
    step(0, 0, N2, N2, 0, 0, 1);
    step(0, 0, N,  N,  0, 0, 1);

    // Single-cycle glitch: blanked once, filter clears, a repeat glitch still does not trip.
    step(0, 0, GL, AR, 0, 0, 1);
    step(0, 0, N,  N,  0, 0, 1);
    step(0, 0, GL, AR, 0, 0, 1);
    step(0, 0, N2, N2, 0, 0, 1);

    // Conflict held two cycles trips FLASH with code 2, then lamps alternate.
    step(0, 0, C,  AR, 0, 0, 1);
    step(0, 0, C,  AR, 1, 2, 2);
    step(0, 0, C,  AO, 1, 2, 2);
    step(0, 0, C,  AR, 1, 2, 2);
    // Clear on a violating sample is ignored.
    step(0, 1, C,  AO, 1, 2, 2);
    // Clear on a legal sample returns to STARTUP.
    step(0, 1, N,  AR, 0, 0, 0);
    step(0, 0, N,  AR, 0, 0, 0);
    step(0, 0, N2, AR, 0, 0, 0);
    step(0, 0, N,  AR, 0, 0, 1);
    step(0, 0, N2, N2, 0, 0, 1);

    // Invalid and conflict together: invalid wins the cause code.
    step(0, 0, IC, AR, 0, 0, 1);
    step(0, 0, IC, AR, 1, 1, 2);
    step(0, 0, IC, AO, 1, 1, 2);
    // Reset in the middle of FLASH discards the fault.
    step(1, 0, N,  AR, 0, 0, 0);
    step(0, 0, N,  AR, 0, 0, 0);
    step(0, 0, N2, AR, 0, 0, 0);
    step(0, 0, N,  AR, 0, 0, 1);

    // Stuck boundary: 15 repeats of one vector then a change must not trip.
    step(0, 0, N2, N2, 0, 0, 1);
    for (int i = 0; i < 15; i++) step(0, 0, N2, N2, 0, 0, 1);
    step(0, 0, N,  N,  0, 0, 1);
    // 16th repeat of an unchanged vector trips with code 3.
    for (int i = 0; i < 15; i++) step(0, 0, N, N, 0, 0, 1);
    step(0, 0, N,  AR, 1, 3, 2);
    step(0, 0, N,  AO, 1, 3, 2);
    step(0, 1, N,  AR, 0, 0, 0);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    #3;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
